// File: rtl/bus_arbiter_rr_if.sv
// Shared-bus signal bundle between four requesters and the round-robin arbiter.
// The master side drives requests and source data; the slave side drives grant, select and bus.
interface bus_arbiter_rr_if #(
    parameter int N = 8
);
    logic [3:0]   req;
    logic [N-1:0] d0;
    logic [N-1:0] d1;
    logic [N-1:0] d2;
    logic [N-1:0] d3;
    logic [3:0]   grant;
    logic [1:0]   sel;
    logic [N-1:0] bus_out;
    logic         busy;
    logic         timeout;

    modport master (
        output req, d0, d1, d2, d3,
        input  grant, sel, bus_out, busy, timeout
    );

    modport slave (
        input  req, d0, d1, d2, d3,
        output grant, sel, bus_out, busy, timeout
    );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter with hold limit and registered bus driver for four requesters.
// grant, sel, bus_out and timeout are all registered and track the same cycle.
module bus_arbiter_rr #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_rr_if.slave bus
);
    localparam int HW = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        r_state;
    logic [1:0]    r_owner;
    logic [1:0]    r_last;
    logic [HW-1:0] r_hold;
    logic [3:0]    r_grant;
    logic [1:0]    r_sel;
    logic [N-1:0]  r_bus;
    logic          r_busy;
    logic          r_timeout;

    state_t        w_state_nxt;
    logic [1:0]    w_owner_nxt;
    logic [1:0]    w_last_nxt;
    logic [HW-1:0] w_hold_nxt;
    logic          w_timeout_nxt;
    logic [3:0]    w_others;
    logic [2:0]    w_pick_idle;
    logic [2:0]    w_pick_oth;
    logic [3:0]    w_grant_nxt;
    logic [1:0]    w_sel_nxt;
    logic [N-1:0]  w_bus_nxt;
    logic          w_busy_nxt;

    // Returns {found, index}; scan starts just after base and wraps, base itself last.
    function automatic logic [2:0] f_pick(input logic [3:0] mask, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = base + 2'(k);
            if (!res[2] && mask[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign w_others    = bus.req & ~(4'b0001 << r_owner);
    assign w_pick_idle = f_pick(bus.req, r_last);
    assign w_pick_oth  = f_pick(w_others, r_owner);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_owner   <= '0;
            r_last    <= 2'd3;
            r_hold    <= '0;
            r_grant   <= '0;
            r_sel     <= '0;
            r_bus     <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_last    <= w_last_nxt;
            r_hold    <= w_hold_nxt;
            r_grant   <= w_grant_nxt;
            r_sel     <= w_sel_nxt;
            r_bus     <= w_bus_nxt;
            r_busy    <= w_busy_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_last_nxt    = r_last;
        w_hold_nxt    = r_hold;
        w_timeout_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                w_hold_nxt = '0;
                if (w_pick_idle[2]) begin
                    w_state_nxt = GRANT;
                    w_owner_nxt = w_pick_idle[1:0];
                end
            end
            GRANT: begin
                if (!bus.req[r_owner]) begin
                    w_last_nxt = r_owner;
                    w_hold_nxt = '0;
                    if (w_pick_oth[2]) begin
                        w_owner_nxt = w_pick_oth[1:0];
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (r_hold == HOLD_LAST) begin
                    // A sole requester saturates here until someone else asks.
                    if (w_pick_oth[2]) begin
                        w_last_nxt    = r_owner;
                        w_owner_nxt   = w_pick_oth[1:0];
                        w_hold_nxt    = '0;
                        w_timeout_nxt = 1'b1;
                    end
                end else begin
                    w_hold_nxt = r_hold + HW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_grant_nxt = '0;
        w_sel_nxt   = '0;
        w_bus_nxt   = '0;
        w_busy_nxt  = 1'b0;
        if (w_state_nxt == GRANT) begin
            w_grant_nxt = 4'b0001 << w_owner_nxt;
            w_sel_nxt   = w_owner_nxt;
            w_busy_nxt  = 1'b1;
            case (w_owner_nxt)
                2'd0:    w_bus_nxt = bus.d0;
                2'd1:    w_bus_nxt = bus.d1;
                2'd2:    w_bus_nxt = bus.d2;
                default: w_bus_nxt = bus.d3;
            endcase
        end
    end

    assign bus.grant   = r_grant;
    assign bus.sel     = r_sel;
    assign bus.bus_out = r_bus;
    assign bus.busy    = r_busy;
    assign bus.timeout = r_timeout;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench for bus_arbiter_rr: a behavioural reference queues expected outputs per edge.
// Directed sequences cover priority rotation, hold-limit release, saturation and async reset.
module tb_bus_arbiter_rr;
    localparam int N    = 8;
    localparam int MAXH = 16;

    typedef struct {
        logic [3:0]   g;
        logic [1:0]   s;
        logic [N-1:0] b;
        logic         busy;
        logic         to;
    } exp_t;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;
    exp_t sb[$];

    int m_own;
    int m_last;
    int m_hold;

    logic [3:0] obs_g;
    logic       obs_to;

    bus_arbiter_rr_if #(.N(N)) ifc ();

    bus_arbiter_rr #(.N(N), .MAX_HOLD(MAXH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int search(input logic [3:0] r, input int base);
        for (int k = 1; k <= 4; k++) begin
            if (r[(base + k) % 4]) return (base + k) % 4;
        end
        return -1;
    endfunction

    // Advance the reference by one edge; returns the expected timeout pulse.
    function automatic logic model_step(input logic [3:0] r);
        logic [3:0] oth;
        logic       to;
        to = 1'b0;
        if (m_own < 0) begin
            m_own  = search(r, m_last);
            m_hold = 0;
        end else if (!r[m_own]) begin
            m_last = m_own;
            m_own  = search(r, m_own);
            m_hold = 0;
        end else begin
            oth = r;
            oth[m_own] = 1'b0;
            if (m_hold == MAXH - 1) begin
                if (oth != 4'b0) begin
                    m_last = m_own;
                    m_own  = search(oth, m_own);
                    m_hold = 0;
                    to     = 1'b1;
                end
            end else begin
                m_hold++;
            end
        end
        return to;
    endfunction

    task automatic step(input logic [3:0] r, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] c, input logic [N-1:0] e);
        exp_t         x;
        logic [N-1:0] dv [4];
        ifc.req = r;
        ifc.d0  = a;
        ifc.d1  = b;
        ifc.d2  = c;
        ifc.d3  = e;
        dv[0] = a; dv[1] = b; dv[2] = c; dv[3] = e;
        x.to   = model_step(r);
        x.g    = (m_own < 0) ? 4'b0 : (4'b0001 << m_own);
        x.s    = (m_own < 0) ? 2'd0 : 2'(m_own);
        x.b    = (m_own < 0) ? '0 : dv[m_own];
        x.busy = (m_own >= 0);
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            x = sb.pop_front();
            chk("grant",   32'(ifc.grant),   32'(x.g));
            chk("sel",     32'(ifc.sel),     32'(x.s));
            chk("bus_out", 32'(ifc.bus_out), 32'(x.b));
            chk("busy",    32'(ifc.busy),    32'(x.busy));
            chk("timeout", 32'(ifc.timeout), 32'(x.to));
        end
        obs_g  = ifc.grant;
        obs_to = ifc.timeout;
    endtask

    task automatic rstep(input logic [3:0] r);
        step(r, N'($urandom), N'($urandom), N'($urandom), N'($urandom));
    endtask

    task automatic model_reset();
        m_own  = -1;
        m_last = 3;
        m_hold = 0;
    endtask

    task automatic do_reset();
        ifc.req = '0;
        rst = 1'b1;
        model_reset();
        #2;
        chk("rst_grant",   32'(ifc.grant),   32'd0);
        chk("rst_sel",     32'(ifc.sel),     32'd0);
        chk("rst_bus",     32'(ifc.bus_out), 32'd0);
        chk("rst_busy",    32'(ifc.busy),    32'd0);
        chk("rst_timeout", 32'(ifc.timeout), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] g3 [33];
        logic       t3 [33];
        logic [3:0] rq;
        logic [3:0] seq2 [5];
        logic [3:0] exp2 [5];
        int         nto;
        int         nbadg;
        n_total = 0;
        n_bad   = 0;
        rst     = 1'b1;
        ifc.req = '0;
        ifc.d0  = '0;
        ifc.d1  = '0;
        ifc.d2  = '0;
        ifc.d3  = '0;

        // 1: first grant after reset
        do_reset();
        step(4'b0101, 8'hA5, 8'h11, 8'h22, 8'h33);
        chk("t1_grant", 32'(ifc.grant), 32'h1);
        chk("t1_bus",   32'(ifc.bus_out), 32'hA5);

        // 2: each owner drops one cycle after grant
        do_reset();
        seq2[0] = 4'b1111; seq2[1] = 4'b1110; seq2[2] = 4'b1101; seq2[3] = 4'b1011; seq2[4] = 4'b0111;
        exp2[0] = 4'b0001; exp2[1] = 4'b0010; exp2[2] = 4'b0100; exp2[3] = 4'b1000; exp2[4] = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            rstep(seq2[i]);
            chk("t2_grant", 32'(obs_g), 32'(exp2[i]));
            chk("t2_to",    32'(obs_to), 32'd0);
        end

        // 3: hold limit forces alternation
        do_reset();
        for (int i = 0; i < 33; i++) begin
            rstep(4'b0011);
            g3[i] = obs_g;
            t3[i] = obs_to;
        end
        chk("t3_g15", 32'(g3[15]), 32'h1);
        chk("t3_t15", 32'(t3[15]), 32'h0);
        chk("t3_g16", 32'(g3[16]), 32'h2);
        chk("t3_t16", 32'(t3[16]), 32'h1);
        chk("t3_t17", 32'(t3[17]), 32'h0);
        chk("t3_g31", 32'(g3[31]), 32'h2);
        chk("t3_g32", 32'(g3[32]), 32'h1);
        chk("t3_t32", 32'(t3[32]), 32'h1);

        // 4: sole requester saturates, then forced off
        do_reset();
        nto   = 0;
        nbadg = 0;
        for (int i = 0; i < 40; i++) begin
            rstep(4'b0100);
            if (obs_to) nto++;
            if (obs_g != 4'b0100) nbadg++;
        end
        chk("t4_to_cnt", 32'(nto), 32'd0);
        chk("t4_g_bad",  32'(nbadg), 32'd0);
        rstep(4'b0101);
        chk("t4_grant", 32'(obs_g), 32'h1);
        chk("t4_to",    32'(obs_to), 32'h1);

        // 5: asynchronous reset mid-cycle
        do_reset();
        rstep(4'b1000);
        chk("t5_pre", 32'(obs_g), 32'h8);
        ifc.req = 4'b1001;
        #3;
        rst = 1'b1;
        #1;
        chk("t5_async_grant", 32'(ifc.grant),   32'd0);
        chk("t5_async_busy",  32'(ifc.busy),    32'd0);
        chk("t5_async_bus",   32'(ifc.bus_out), 32'd0);
        chk("t5_async_sel",   32'(ifc.sel),     32'd0);
        #1;
        rst = 1'b0;
        model_reset();
        rstep(4'b1001);
        chk("t5_grant", 32'(obs_g), 32'h1);

        // 6: release to idle, then rotation from last owner
        do_reset();
        rstep(4'b0001);
        rstep(4'b0000);
        chk("t6_idle_g",   32'(ifc.grant),   32'd0);
        chk("t6_idle_bus", 32'(ifc.bus_out), 32'd0);
        rstep(4'b0011);
        chk("t6_grant", 32'(obs_g), 32'h2);

        // Random traffic with sticky requests so the hold limit is exercised
        do_reset();
        rq = 4'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) rq = 4'($urandom);
            rstep(rq);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
